// File: rtl/sram_scan_op_seq_if.sv
// Request/response bundle for the SRAM scan operation sequencer.
//   req_*  : one SRAM access (addr, write data, write enable, write mask)
//            offered with a valid/ready handshake.
//   rsp_*  : read data returned with a valid/ready handshake.
// master drives requests and accepts responses; slave is the sequencer.
interface sram_scan_op_seq_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  req_we;
    logic [MASK_WIDTH-1:0] req_wmask;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_addr, req_data, req_we, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_we, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sram_scan_op_seq.sv
// Turns one request into a full scan-driven SRAM access: serialises
// {addr, data, we, wmask} MSB-first into the control chain, strobes the
// SRAM, and for reads parallel-loads and shifts out the dout chain and
// returns the word on the response channel.
// Ports:
//   clk, rstb      : clock, async active-low reset
//   bus (slave)    : req valid/ready + fields, rsp valid/ready + data
//   busy           : high whenever not IDLE
//   ctl_scan_en/in : control chain shift enable / serial data
//   sram_fire      : one-cycle SRAM operation strobe
//   dout_load      : one-cycle dout chain parallel-load strobe
//   dout_scan_en   : dout chain shift enable
//   dout_scan_out  : dout chain serial output (chain MSB)
module sram_scan_op_seq #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rstb,
    sram_scan_op_seq_if.slave bus,
    output logic              busy,
    output logic              ctl_scan_en,
    output logic              ctl_scan_in,
    output logic              sram_fire,
    output logic              dout_load,
    output logic              dout_scan_en,
    input  logic              dout_scan_out
);
    localparam int CTL_WIDTH = ADDR_WIDTH + DATA_WIDTH + 1 + MASK_WIDTH;
    localparam int MAX_LEN   = (CTL_WIDTH > DATA_WIDTH) ? CTL_WIDTH : DATA_WIDTH;
    localparam int CNT_W     = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {IDLE, SHIFT_CTL, FIRE, LOAD, SHIFT_OUT, RESP} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  we;
        logic [MASK_WIDTH-1:0] wmask;
    } ctl_word_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    ctl_word_t             w_q, w_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [CTL_WIDTH-1:0]  w_bits;
    logic [DATA_WIDTH-1:0] sr_shift;

    assign w_bits   = w_q;
    assign sr_shift = {sr_q[DATA_WIDTH-2:0], dout_scan_out};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        w_d        = w_q;
        sr_d       = sr_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    w_d     = '{addr: bus.req_addr, data: bus.req_data,
                                we: bus.req_we, wmask: bus.req_wmask};
                    cnt_d   = CNT_W'(CTL_WIDTH - 1);
                    state_d = SHIFT_CTL;
                end
            end
            SHIFT_CTL: begin
                // cnt walks CTL_WIDTH-1..0 and doubles as the bit index,
                // so the word leaves MSB first.
                if (cnt_q == '0) begin
                    state_d = FIRE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIRE: begin
                cnt_d   = '0;
                state_d = w_q.we ? IDLE : LOAD;
            end
            LOAD: begin
                cnt_d   = CNT_W'(DATA_WIDTH - 1);
                state_d = SHIFT_OUT;
            end
            SHIFT_OUT: begin
                sr_d = sr_shift;
                if (cnt_q == '0) begin
                    // Separate holding register so rsp_data stays put while
                    // the next read is shifting in.
                    rsp_data_d = sr_shift;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                cnt_d = '0;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            w_q        <= '0;
            sr_q       <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            w_q        <= w_d;
            sr_q       <= sr_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Everything below decodes registered state only, so strobes are
    // mutually exclusive by construction.
    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state_q != IDLE);
    assign ctl_scan_en   = (state_q == SHIFT_CTL);
    assign ctl_scan_in   = (state_q == SHIFT_CTL) & w_bits[cnt_q];
    assign sram_fire     = (state_q == FIRE);
    assign dout_load     = (state_q == LOAD);
    assign dout_scan_en  = (state_q == SHIFT_OUT);
endmodule

// File: tb/tb_sram_scan_op_seq.sv
module tb_sram_scan_op_seq;
    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        busy, ctl_scan_en, ctl_scan_in, sram_fire, dout_load, dout_scan_en;
    logic        dout_scan_out;
    logic [41:0] ctl_chain = '0;
    logic [31:0] dout_chain = '0;
    logic [31:0] dout_val = '0;
    int          checks = 0;
    int          errors = 0;
    bit          pre_valid = 1'b0;
    logic [4:0]  pre_addr = '0;

    sram_scan_op_seq_if bus ();

    sram_scan_op_seq dut (
        .clk           (clk),
        .rstb          (rstb),
        .bus           (bus.slave),
        .busy          (busy),
        .ctl_scan_en   (ctl_scan_en),
        .ctl_scan_in   (ctl_scan_in),
        .sram_fire     (sram_fire),
        .dout_load     (dout_load),
        .dout_scan_en  (dout_scan_en),
        .dout_scan_out (dout_scan_out)
    );

    always #5 clk = ~clk;

    // Chain models: control chain collects the serial stream, dout chain
    // loads dout_val and shifts toward its MSB output.
    always @(posedge clk) begin
        if (ctl_scan_en) ctl_chain <= {ctl_chain[40:0], ctl_scan_in};
        if (dout_load) dout_chain <= dout_val;
        else if (dout_scan_en) dout_chain <= {dout_chain[30:0], 1'b0};
    end
    assign dout_scan_out = dout_chain[31];

    always @(negedge clk) begin
        if (rstb) begin
            checks++;
            assert ($countones({ctl_scan_en, sram_fire, dout_load, dout_scan_en}) <= 1)
            else begin
                errors++;
                $error("FAIL strobe_excl obs=%b exp=onehot0",
                       {ctl_scan_en, sram_fire, dout_load, dout_scan_en});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Runs one transaction from the acceptance cycle (cycle 0). Reads end
    // in cycle 77 with the response still pending.
    task automatic do_op(input logic [4:0] a, input logic [31:0] d, input logic we,
                         input logic [3:0] m, input bit poke);
        logic [41:0] w;
        w = {a, d, we, m};
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.req_we    = we;
        bus.req_wmask = m;
        bus.req_valid = 1'b1;
        chk1("accept_ready", bus.req_ready, 1'b1);
        for (int c = 1; c <= 42; c++) begin
            tick;
            if (c == 1) bus.req_valid = 1'b0;
            if (poke && c == 20) begin
                bus.req_valid = 1'b1;
                bus.req_addr  = ~a;
                bus.req_data  = ~d;
                bus.req_we    = ~we;
                bus.req_wmask = ~m;
            end
            if (poke && c == 21) bus.req_valid = 1'b0;
            chk1("ctl_en", ctl_scan_en, 1'b1);
            chk1("ctl_bit", ctl_scan_in, w[42-c]);
            chk1("ready_busy", bus.req_ready, 1'b0);
            chk1("busy", busy, 1'b1);
            chk1("no_rsp", bus.rsp_valid, 1'b0);
        end
        tick; // cycle 43
        chk1("fire", sram_fire, 1'b1);
        chk1("fire_ctl_off", ctl_scan_en, 1'b0);
        chkv("ctl_word", 64'(ctl_chain), 64'(w));
        if (we) begin
            if (pre_valid) begin
                bus.req_addr  = pre_addr;
                bus.req_data  = 32'h0;
                bus.req_we    = 1'b0;
                bus.req_wmask = 4'h0;
                bus.req_valid = 1'b1;
            end
            tick; // cycle 44
            chk1("wr_ready", bus.req_ready, 1'b1);
            chk1("wr_idle", busy, 1'b0);
            chk1("wr_no_rsp", bus.rsp_valid, 1'b0);
        end else begin
            tick; // cycle 44
            chk1("load", dout_load, 1'b1);
            for (int c = 45; c <= 76; c++) begin
                tick;
                chk1("dout_en", dout_scan_en, 1'b1);
                chk1("rd_no_rsp", bus.rsp_valid, 1'b0);
            end
            tick; // cycle 77
            chk1("rsp_valid", bus.rsp_valid, 1'b1);
            chkv("rsp_data", 64'(bus.rsp_data), 64'(dout_val));
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_we    = 1'b0;
        bus.req_wmask = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        #12;
        chk1("rst_ready", bus.req_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chkv("rst_rsp_data", 64'(bus.rsp_data), 64'h0);
        chk1("rst_strobes", ctl_scan_en | ctl_scan_in | sram_fire | dout_load | dout_scan_en, 1'b0);
        @(negedge clk);
        rstb = 1'b1;
        tick;

        // Write, then the hand-packed control word
        do_op(5'h1F, 32'hDEADBEEF, 1'b1, 4'hA, 1'b0);
        chkv("wr_word_const", 64'(ctl_chain), 64'h3FB_D5B7_DDFA);

        // Read with backpressure
        dout_val = 32'h12345678;
        do_op(5'h03, 32'h0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk1("bp_valid", bus.rsp_valid, 1'b1);
            chkv("bp_data", 64'(bus.rsp_data), 64'h12345678);
            chk1("bp_ready", bus.req_ready, 1'b0);
        end
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
        chk1("hs_valid_drop", bus.rsp_valid, 1'b0);
        chk1("hs_ready", bus.req_ready, 1'b1);
        chkv("hs_data_hold", 64'(bus.rsp_data), 64'h12345678);

        // Write with a request poked at cycle 20
        do_op(5'h0A, 32'h0F0F0055, 1'b1, 4'h5, 1'b1);

        // Reset during SHIFT_OUT
        dout_val = 32'hCAFE0001;
        bus.req_addr  = 5'h03;
        bus.req_we    = 1'b0;
        bus.req_valid = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick;
            if (c == 1) bus.req_valid = 1'b0;
        end
        chk1("mid_shift", dout_scan_en, 1'b1);
        rstb = 1'b0;
        #1;
        chk1("mid_rst_ready", bus.req_ready, 1'b1);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_dout_en", dout_scan_en, 1'b0);
        chkv("mid_rst_data", 64'(bus.rsp_data), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk1("mid_rst_no_rsp", bus.rsp_valid, 1'b0);
        end
        @(negedge clk);
        rstb = 1'b1;
        dout_val = 32'h0F1E2D3C;
        do_op(5'h03, 32'h0, 1'b0, 4'h0, 1'b0);
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
        chk1("post_rst_done", bus.rsp_valid, 1'b0);

        // Back-to-back write then read (read fires at absolute cycle 87)
        pre_valid = 1'b1;
        pre_addr  = 5'h11;
        dout_val  = 32'h80000001;
        do_op(5'h02, 32'h55AA00FF, 1'b1, 4'h3, 1'b0);
        do_op(5'h11, 32'h0, 1'b0, 4'h0, 1'b0);
        pre_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
        chk1("b2b_done", bus.req_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
